// File: rtl/usb_tx_line_encoder_pkg.sv
// usb_tx_line_encoder_pkg: line states, transmit FSM states and default parameters
package usb_tx_line_encoder_pkg;
    localparam int DEFAULT_STUFF_LEN = 6;
    localparam int DEFAULT_EOP_SE0 = 2;
    typedef enum logic [1:0] {LINE_SE0 = 2'b00, LINE_K = 2'b01, LINE_J = 2'b10} line_t;
    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_STUFF, ST_EOP_SE0, ST_EOP_J} tx_state_t;
endpackage

// File: rtl/usb_tx_line_encoder_if.sv
// usb_tx_line_encoder_if: raw bit stream from the serialisers into the line encoder
interface usb_tx_line_encoder_if;
    logic in_valid;
    logic in_bit;
    logic in_last;
    logic in_ready;
    modport master (output in_valid, in_bit, in_last, input in_ready);
    modport slave (input in_valid, in_bit, in_last, output in_ready);
endinterface

// File: rtl/usb_tx_line_encoder_nrzi_line_drv.sv
// nrzi_line_drv: registered NRZI level and J/K/SE0 mux onto the D+/D- pair
module nrzi_line_drv
    import usb_tx_line_encoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_j,
    input  logic toggle,
    input  logic se0,
    output logic dp,
    output logic dm
);
    logic lvl_q, lvl_d;
    line_t line_q, line_d;
    always_comb begin
        lvl_d = load_j ? 1'b1 : lvl_q ^ toggle;
        line_d = se0 ? LINE_SE0 : lvl_d ? LINE_J : LINE_K;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= 1'b1;
            line_q <= LINE_J;
        end else begin
            lvl_q <= lvl_d;
            line_q <= line_d;
        end
    end
    assign {dp, dm} = line_q;
endmodule

// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder: bit stuffing, NRZI encoding and EOP generation for USB transmit
module usb_tx_line_encoder
    import usb_tx_line_encoder_pkg::*;
#(
    parameter int STUFF_LEN = DEFAULT_STUFF_LEN,
    parameter int EOP_SE0 = DEFAULT_EOP_SE0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    usb_tx_line_encoder_if.slave s,
    output logic dp,
    output logic dm,
    output logic busy,
    output logic done,
    output logic underrun
);
    localparam int W = $clog2(STUFF_LEN + 1);
    localparam int E = $clog2(EOP_SE0 + 1);
    tx_state_t state_q, state_d;
    logic [W-1:0] ones_q, ones_d;
    logic [E-1:0] eop_q, eop_d;
    logic last_pend_q, last_pend_d;
    logic underrun_q, underrun_d;
    logic done_q, done_d;
    logic load_j, toggle, se0;
    assign s.in_ready = state_q == ST_SEND;
    always_comb begin
        state_d = state_q;
        ones_d = ones_q;
        eop_d = eop_q;
        last_pend_d = last_pend_q;
        underrun_d = underrun_q;
        done_d = 1'b0;
        load_j = 1'b0;
        toggle = 1'b0;
        se0 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_j = 1'b1;
                if (start) begin
                    state_d = ST_SEND;
                    underrun_d = 1'b0;
                    ones_d = '0;
                end
            end
            ST_SEND: begin
                if (!s.in_valid) underrun_d = 1'b1;
                else begin
                    toggle = ~s.in_bit;
                    ones_d = s.in_bit ? ones_q + W'(1) : '0;
                    if (s.in_bit && ones_q == W'(STUFF_LEN - 1)) begin
                        state_d = ST_STUFF;
                        last_pend_d = s.in_last;
                    end else if (s.in_last) state_d = ST_EOP_SE0;
                end
            end
            ST_STUFF: begin
                toggle = 1'b1;
                ones_d = '0;
                state_d = last_pend_q ? ST_EOP_SE0 : ST_SEND;
            end
            ST_EOP_SE0: begin
                se0 = 1'b1;
                eop_d = eop_q == E'(EOP_SE0 - 1) ? '0 : eop_q + E'(1);
                state_d = eop_q == E'(EOP_SE0 - 1) ? ST_EOP_J : ST_EOP_SE0;
            end
            ST_EOP_J: begin
                load_j = 1'b1;
                done_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ones_q <= '0;
            eop_q <= '0;
            last_pend_q <= 1'b0;
            underrun_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q <= ones_d;
            eop_q <= eop_d;
            last_pend_q <= last_pend_d;
            underrun_q <= underrun_d;
            done_q <= done_d;
        end
    end
    nrzi_line_drv u_drv (
        .clk(clk),
        .rst(rst),
        .load_j(load_j),
        .toggle(toggle),
        .se0(se0),
        .dp(dp),
        .dm(dm)
    );
    assign busy = state_q != ST_IDLE;
    assign done = done_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb_usb_tx_line_encoder: directed vectors against hand-computed line sequences
module tb_usb_tx_line_encoder;
    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] Z = 2'b00;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic dp, dm, busy, done, underrun;
    int n_cmp = 0;
    int n_err = 0;
    usb_tx_line_encoder_if bus ();
    usb_tx_line_encoder dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .s(bus),
        .dp(dp),
        .dm(dm),
        .busy(busy),
        .done(done),
        .underrun(underrun)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask
    task automatic tx_bit(input logic b, input logic last, input logic [1:0] exp);
        bus.in_valid = 1'b1;
        bus.in_bit = b;
        bus.in_last = last;
        chk("ready_send", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        chk("line_bit", {dp, dm}, exp);
    endtask
    task automatic stuff_cycle(input logic [1:0] exp);
        chk("ready_stuff", bus.in_ready, 1'b0);
        step();
        chk("line_stuff", {dp, dm}, exp);
    endtask
    task automatic eop_tail();
        step();
        chk("eop_se0_1", {dp, dm}, Z);
        chk("eop_no_done", done, 1'b0);
        step();
        chk("eop_se0_2", {dp, dm}, Z);
        step();
        chk("eop_j", {dp, dm}, J);
        chk("eop_done", done, 1'b1);
        chk("eop_busy", busy, 1'b0);
        step();
        chk("done_pulse_end", done, 1'b0);
        chk("idle_j", {dp, dm}, J);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.in_last = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_line", {dp, dm}, J);
        chk("rst_ready", bus.in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        go();
        for (int i = 0; i < 7; i++) tx_bit(1'b0, 1'b0, (i % 2 == 0) ? K : J);
        tx_bit(1'b1, 1'b1, K);
        eop_tail();
        go();
        for (int i = 0; i < 6; i++) tx_bit(1'b1, 1'b0, J);
        stuff_cycle(K);
        tx_bit(1'b1, 1'b0, K);
        tx_bit(1'b0, 1'b1, J);
        eop_tail();
        go();
        for (int i = 0; i < 5; i++) tx_bit(1'b1, 1'b0, J);
        tx_bit(1'b1, 1'b1, J);
        stuff_cycle(K);
        eop_tail();
        go();
        chk("underrun_clear0", underrun, 1'b0);
        tx_bit(1'b0, 1'b0, K);
        tx_bit(1'b1, 1'b0, K);
        for (int i = 0; i < 3; i++) begin
            chk("ready_hold", bus.in_ready, 1'b1);
            start = (i == 1);
            step();
            chk("line_hold", {dp, dm}, K);
            chk("underrun_set", underrun, 1'b1);
        end
        start = 1'b0;
        tx_bit(1'b0, 1'b0, J);
        tx_bit(1'b0, 1'b1, K);
        eop_tail();
        chk("underrun_sticky", underrun, 1'b1);
        go();
        chk("underrun_cleared", underrun, 1'b0);
        for (int i = 0; i < 5; i++) tx_bit(1'b1, 1'b0, J);
        tx_bit(1'b1, 1'b0, J);
        chk("in_stuff_ready", bus.in_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_stuff_line", {dp, dm}, J);
        chk("rst_stuff_busy", busy, 1'b0);
        chk("rst_stuff_done", done, 1'b0);
        step();
        chk("rst_stuff_done2", done, 1'b0);
        chk("rst_stuff_line2", {dp, dm}, J);
        go();
        tx_bit(1'b1, 1'b1, J);
        step();
        chk("pre_rst_se0", {dp, dm}, Z);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_eop_line", {dp, dm}, J);
        chk("rst_eop_busy", busy, 1'b0);
        chk("rst_eop_done", done, 1'b0);
        step();
        chk("rst_eop_done2", done, 1'b0);
        chk("rst_eop_line2", {dp, dm}, J);
        go();
        for (int i = 0; i < 5; i++) tx_bit(1'b1, 1'b0, J);
        tx_bit(1'b0, 1'b1, K);
        eop_tail();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
